// File: rtl/cla_serial_adder_pkg.sv
// Shared definitions for the nibble-serial CLA adder: FSM encoding, nibble width
// and a ceiling-log2 helper used to size the nibble counter.
package cla_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int NIBBLE = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_serial_adder_if.sv
// Request/result bundle of the serial adder; master issues operands, slave
// returns status and the registered result.
interface cla_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/cla_serial_adder_cla4.sv
// Existing 4-bit carry-lookahead slice (CLA4bit): purely combinational
// a + b + cin with all carries computed from generate/propagate terms.
module cla_serial_adder_cla4
  import cla_serial_adder_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] sum,
  output logic              cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_serial_adder.sv
// WIDTH-bit adder that streams operands LSB nibble first through a single CLA
// slice, one nibble per clock, with a registered inter-nibble carry.
module cla_serial_adder
  import cla_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  cla_serial_adder_if.slave bus
);

  localparam int NIB   = WIDTH / NIBBLE;
  localparam int CNT_W = (clog2(NIB) < 1) ? 1 : clog2(NIB);

  state_t state;
  state_t state_nx;
  logic   load;
  logic   step;
  logic   fin;

  logic [WIDTH-1:0]        a_sh;
  logic [WIDTH-1:0]        b_sh;
  logic [WIDTH-NIBBLE-1:0] sum_sh;
  logic                    carry;
  logic [CNT_W-1:0]        cnt;

  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_ovf;

  logic [NIBBLE-1:0] slice_sum;
  logic              slice_cout;
  logic              c_msb;
  logic [WIDTH-1:0]  sum_cat;

  cla_serial_adder_cla4 u_cla (
    .a    (a_sh[NIBBLE-1:0]),
    .b    (b_sh[NIBBLE-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Carry into the MSB recovered from the top slice's sum bit and its operands.
  assign c_msb   = a_sh[NIBBLE-1] ^ b_sh[NIBBLE-1] ^ slice_sum[NIBBLE-1];
  // New nibble enters from the top; on the last step this is the complete sum.
  assign sum_cat = {slice_sum, sum_sh};

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    fin      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_W'(NIB - 1)) begin
          fin      = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_ovf  <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        a_sh  <= bus.a;
        b_sh  <= bus.b;
        carry <= bus.cin;
        cnt   <= '0;
      end else if (step) begin
        a_sh   <= a_sh >> NIBBLE;
        b_sh   <= b_sh >> NIBBLE;
        carry  <= slice_cout;
        sum_sh <= sum_cat[WIDTH-1:NIBBLE];
        cnt    <= fin ? '0 : cnt + CNT_W'(1);
      end
      if (fin) begin
        res_sum  <= sum_cat;
        res_cout <= slice_cout;
        res_ovf  <= c_msb ^ slice_cout;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = res_sum;
  assign bus.cout = res_cout;
  assign bus.ovf  = res_ovf;

endmodule
